// File: rtl/add_accumulator.sv
// Streaming unsigned accumulator: sums a programmed number of samples and
// presents the total with a sticky carry-out flag on a valid/ready port.
module add_accumulator #(
    parameter int DATAWIDTH  = 32,
    parameter int COUNTWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [COUNTWIDTH-1:0] len,
    input  logic [DATAWIDTH-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATAWIDTH-1:0]  out_sum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [DATAWIDTH-1:0]  acc_q, acc_d;
    logic [COUNTWIDTH-1:0] cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [DATAWIDTH:0]    sum_ext;
    logic                  beat;

    assign sum_ext = {1'b0, acc_q} + {1'b0, in_data};
    assign beat    = (state_q == ACCUM) && in_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: defaults assigned first in every combinational block, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (len == '0) ? HOLD : ACCUM;
            ACCUM:   if (beat && cnt_q == COUNTWIDTH'(1)) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (state_q == IDLE && start) begin
            acc_d = '0;
            ovf_d = 1'b0;
            cnt_d = len;
        end else if (beat) begin
            acc_d = sum_ext[DATAWIDTH-1:0];
            ovf_d = ovf_q | sum_ext[DATAWIDTH];
            cnt_d = cnt_q - COUNTWIDTH'(1);
        end
    end

    // Outputs decode from state only; no input-to-output combinational path.
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == HOLD);
        busy      = (state_q == ACCUM) || (state_q == HOLD);
    end

    assign out_sum  = acc_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_add_accumulator.sv
// Directed + randomized-chaining bench for add_accumulator with immediate
// assertions at each comparison and a reference model of the ADD stage.
module tb_add_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_sum;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    add_accumulator #(.DATAWIDTH(32), .COUNTWIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".in_ready"},  32'(in_ready),  32'd0);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".busy"},      32'(busy),      32'd0);
        check({tag, ".out_sum"},   out_sum,        32'd0);
        check({tag, ".overflow"},  32'(overflow),  32'd0);
    endtask

    task automatic beat(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [32:0] model;
        logic        model_ovf;
        logic [31:0] a, b;
        logic [7:0]  rlen;
        int          sent, guard;
        logic        got;

        rst = 1'b1; start = 1'b0; len = '0; in_data = '0;
        in_valid = 1'b0; out_ready = 1'b0;

        // Reset and idle behaviour.
        repeat (10) step();
        check_idle("reset");
        rst = 1'b0;
        in_valid = 1'b1; in_data = 32'd5;
        step(); step();
        in_valid = 1'b0;
        check_idle("idle_no_start");

        // Basic run, back-to-back beats.
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0;
        check("basic.in_ready", 32'(in_ready), 32'd1);
        check("basic.busy",     32'(busy),     32'd1);
        in_valid = 1'b1;
        in_data = 32'd10; step();
        in_data = 32'd20; step();
        in_data = 32'd30; step();
        in_valid = 1'b0; out_ready = 1'b1;
        check("basic.out_valid", 32'(out_valid), 32'd1);
        check("basic.out_sum",   out_sum,        32'd60);
        check("basic.overflow",  32'(overflow),  32'd0);
        check("basic.in_ready_hold", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b0;
        check("basic.idle_valid", 32'(out_valid), 32'd0);
        check("basic.idle_busy",  32'(busy),      32'd0);

        // Stalls with ignored start pulses during ACCUM, then backpressure.
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            beat(32'(i));
            if (i < 4) begin
                start = 1'b1; len = 8'd9;
                repeat (3) step();
                start = 1'b0;
                check("stall.in_ready", 32'(in_ready), 32'd1);
            end
        end
        start = 1'b1; len = 8'd2;
        for (int i = 0; i < 5; i++) begin
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.out_sum",   out_sum,        32'd10);
            step();
        end
        out_ready = 1'b1;
        step();
        start = 1'b0; out_ready = 1'b0;
        check("bp.start_with_ready_ignored.busy", 32'(busy), 32'd0);
        check("bp.start_with_ready_ignored.in_ready", 32'(in_ready), 32'd0);

        // Overflow and wrap, then a clean run clears the flag.
        start = 1'b1; len = 8'd2;
        step();
        start = 1'b0;
        beat(32'hFFFF_FFFF);
        beat(32'h0000_0002);
        check("wrap.out_valid", 32'(out_valid), 32'd1);
        check("wrap.out_sum",   out_sum,        32'h0000_0001);
        check("wrap.overflow",  32'(overflow),  32'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0;
        beat(32'd7);
        check("after_wrap.out_sum",  out_sum,       32'd7);
        check("after_wrap.overflow", 32'(overflow), 32'd0);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Zero-length run.
        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        check("zero.out_valid", 32'(out_valid), 32'd1);
        check("zero.out_sum",   out_sum,        32'd0);
        check("zero.in_ready",  32'(in_ready),  32'd0);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("zero.done_in_ready", 32'(in_ready),  32'd0);
        check("zero.done_valid",    32'(out_valid), 32'd0);

        // Reset mid-run.
        start = 1'b1; len = 8'd5;
        step();
        start = 1'b0;
        beat(32'd100);
        beat(32'd200);
        rst = 1'b1; step(); rst = 1'b0;
        check_idle("midrun_reset");
        step();
        check_idle("midrun_reset_after");

        // Random chaining: ADD model a+b feeds the accumulator.
        for (int run = 0; run < 200; run++) begin
            rlen = 8'($urandom_range(0, 6));
            model = '0; model_ovf = 1'b0;
            start = 1'b1; len = rlen;
            step();
            start = 1'b0;
            sent = 0; guard = 0;
            while (sent < int'(rlen) && guard < 100) begin
                guard++;
                if ($urandom_range(0, 3) != 0 && in_ready) begin
                    a = $urandom(); b = $urandom();
                    in_valid = 1'b1; in_data = a + b;
                    model = {1'b0, model[31:0]} + {1'b0, a + b};
                    model_ovf = model_ovf | model[32];
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
                step();
            end
            in_valid = 1'b0;
            got = out_valid;
            for (int w = 0; w < 5 && !got; w++) begin
                step();
                got = out_valid;
            end
            check("rand.result_seen", 32'(got),      32'd1);
            check("rand.out_sum",     out_sum,       model[31:0]);
            check("rand.overflow",    32'(overflow), 32'(model_ovf));
            out_ready = 1'b1; step(); out_ready = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
